// File: rtl/controle_adiantamento_if.sv
// Handshake bundle between the ID/EX pipeline and the forwarding/hazard unit.
// Carries ID-stage instruction fields in and mux selects / hazard strobes out.
interface controle_adiantamento_if #(
  parameter int REG_BITS  = 5,
  parameter int CONT_BITS = 16
);
  logic                 id_valido;
  logic [REG_BITS-1:0]  id_rs1;
  logic [REG_BITS-1:0]  id_rs2;
  logic [REG_BITS-1:0]  id_rd;
  logic                 id_escreve_reg;
  logic                 id_le_mem;
  logic                 desvio_tomado;
  logic [1:0]           seletor_a;
  logic [1:0]           seletor_b;
  logic                 stall;
  logic                 flush;
  logic [CONT_BITS-1:0] contador_bolhas;

  modport master (
    output id_valido, id_rs1, id_rs2, id_rd,
    output id_escreve_reg, id_le_mem, desvio_tomado,
    input  seletor_a, seletor_b, stall, flush,
    input  contador_bolhas
  );

  modport slave (
    input  id_valido, id_rs1, id_rs2, id_rd,
    input  id_escreve_reg, id_le_mem, desvio_tomado,
    output seletor_a, seletor_b, stall, flush,
    output contador_bolhas
  );
endinterface

// File: rtl/controle_adiantamento.sv
// Forwarding and hazard control for a 5-stage pipeline.
// Shadows EX/MEM/WB to drive operand selects, load-use stall and flush.
module controle_adiantamento #(
  parameter int REG_BITS  = 5,
  parameter int CONT_BITS = 16
) (
  input logic                    clk,
  input logic                    reset,
  controle_adiantamento_if.slave bus
);

  typedef logic [REG_BITS-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t rs1;
    reg_t rs2;
    reg_t rd;
    logic we;
    logic load;
  } ex_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    logic we;
  } st_t;

  ex_t ex_q, ex_d;
  st_t mem_q, mem_d;
  st_t wb_q, wb_d;
  logic [CONT_BITS-1:0] cont_q, cont_d;

  logic stall, flush;
  logic [1:0] sel_a, sel_b;

  function automatic logic escreve(st_t s, reg_t r);
    return s.valid & s.we & (s.rd == r) & (r != '0);
  endfunction

  function automatic logic [1:0] seleciona(reg_t r);
    logic [1:0] s;
    s = 2'b00;
    if (ex_q.valid) begin
      if (escreve(mem_q, r))
        s = 2'b10;
      else if (escreve(wb_q, r))
        s = 2'b01;
    end
    return s;
  endfunction

  st_t ex_st;
  assign ex_st = '{valid: ex_q.valid, rd: ex_q.rd, we: ex_q.we};

  always_comb begin
    flush = bus.desvio_tomado & ~reset;
    stall = ~reset & ~flush & bus.id_valido & ex_q.load
          & (escreve(ex_st, bus.id_rs1)
           | escreve(ex_st, bus.id_rs2));
    sel_a = seleciona(ex_q.rs1);
    sel_b = seleciona(ex_q.rs2);
  end

  always_comb begin
    ex_d = '0;
    if (bus.id_valido & ~stall & ~flush) begin
      ex_d.valid = 1'b1;
      ex_d.rs1   = bus.id_rs1;
      ex_d.rs2   = bus.id_rs2;
      ex_d.rd    = bus.id_rd;
      ex_d.we    = bus.id_escreve_reg;
      ex_d.load  = bus.id_le_mem;
    end
    mem_d = ex_st;
    wb_d  = mem_q;
    // Saturate instead of wrapping.
    cont_d = cont_q;
    if ((stall | flush) && (cont_q != '1))
      cont_d = cont_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      cont_q <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      cont_q <= cont_d;
    end
  end

  assign bus.seletor_a       = sel_a;
  assign bus.seletor_b       = sel_b;
  assign bus.stall           = stall;
  assign bus.flush           = flush;
  assign bus.contador_bolhas = cont_q;

endmodule
